// File: rtl/alu_multicycle_pkg.sv
// Shared opcode, flag-index and FSM state definitions for the multi-cycle ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_ADDC  = 4'd1,
        OP_SUB   = 4'd2,
        OP_SUBB  = 4'd3,
        OP_AND   = 4'd4,
        OP_OR    = 4'd5,
        OP_XOR   = 4'd6,
        OP_SHL   = 4'd7,
        OP_SHR   = 4'd8,
        OP_DIV   = 4'd9,
        OP_MOD   = 4'd10,
        OP_PASSB = 4'd11
    } op_e;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_S = 2;
    localparam int unsigned FLAG_V = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    function automatic logic is_div_op(input op_e o);
        return (o == OP_DIV) || (o == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the bus controller and the multi-cycle ALU.
interface alu_multicycle_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flag_we;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;
    logic [3:0]       flags;

    modport master (
        output start, op, a, b, flag_we,
        input  result, busy, done, flags
    );

    modport slave (
        input  start, op, a, b, flag_we,
        output result, busy, done, flags
    );
endinterface

// File: rtl/alu_multicycle_div_iter.sv
// Restoring divider: load captures operands, each step cycle retires one quotient bit MSB-first.
module alu_div_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;
    logic             fits;

    // The partial remainder stays below the divisor, so the shifted value needs
    // one extra bit but the post-subtraction value always fits back in WIDTH.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        fits    = (shifted >= {1'b0, dvs_q});
        trial   = shifted[WIDTH-1:0] - dvs_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            quo_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
        end else if (step) begin
            rem_q <= fits ? trial : shifted[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], fits};
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: start/busy/done handshake, iterative DIV/MOD and a Z/C/S/V flags register.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input logic              clk,
    input logic              rst_n,
    alu_multicycle_if.slave  bus
);
    state_e           state;
    logic [CNT_W-1:0] cnt;
    op_e              op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             fwe_q;
    logic             cin_q;
    logic [WIDTH-1:0] result_q;
    logic             busy_q;
    logic             done_q;
    logic [3:0]       flags_q;

    logic             start_div;
    logic             div_load;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    logic             carry_in;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             div_zero;
    logic [WIDTH-1:0] res_c;
    logic             c_c;
    logic             v_c;
    logic             upd_c;

    assign start_div = is_div_op(op_e'(bus.op)) && (bus.b != '0);
    assign div_load  = (state == ST_IDLE) && bus.start && start_div;

    alu_div_iter #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (div_load),
        .step      (state == ST_DIV),
        .dividend  (bus.a),
        .divisor   (bus.b),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always_comb begin
        carry_in = ((op_q == OP_ADDC) || (op_q == OP_SUBB)) ? cin_q : 1'b0;
        sum      = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, carry_in};
        diff     = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, carry_in};
        div_zero = (b_q == '0);
        res_c    = '0;
        c_c      = flags_q[FLAG_C];
        v_c      = 1'b0;
        upd_c    = 1'b1;
        case (op_q)
            OP_ADD, OP_ADDC: begin
                res_c = sum[WIDTH-1:0];
                c_c   = sum[WIDTH];
                v_c   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB, OP_SUBB: begin
                res_c = diff[WIDTH-1:0];
                c_c   = diff[WIDTH];
                v_c   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND:   res_c = a_q & b_q;
            OP_OR:    res_c = a_q | b_q;
            OP_XOR:   res_c = a_q ^ b_q;
            OP_PASSB: res_c = b_q;
            OP_SHL: begin
                res_c = {a_q[WIDTH-2:0], 1'b0};
                c_c   = a_q[WIDTH-1];
            end
            OP_SHR: begin
                res_c = {1'b0, a_q[WIDTH-1:1]};
                c_c   = a_q[0];
            end
            OP_DIV: begin
                res_c = div_zero ? '1 : quotient;
                v_c   = div_zero;
            end
            OP_MOD: begin
                res_c = div_zero ? a_q : remainder;
                v_c   = div_zero;
            end
            default: upd_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            fwe_q    <= 1'b0;
            cin_q    <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            flags_q  <= 4'b0001;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        op_q   <= op_e'(bus.op);
                        a_q    <= bus.a;
                        b_q    <= bus.b;
                        fwe_q  <= bus.flag_we;
                        cin_q  <= flags_q[FLAG_C];
                        busy_q <= 1'b1;
                        if (start_div) begin
                            state <= ST_DIV;
                            cnt   <= CNT_W'(WIDTH);
                        end else begin
                            state <= ST_FIN;
                        end
                    end
                end
                ST_DIV: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    result_q <= res_c;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state    <= ST_IDLE;
                    if (fwe_q && upd_c) begin
                        flags_q[FLAG_Z] <= (res_c == '0);
                        flags_q[FLAG_C] <= c_c;
                        flags_q[FLAG_S] <= res_c[WIDTH-1];
                        flags_q[FLAG_V] <= v_c;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.flags  = flags_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: vector table plus abort/ignore/back-to-back sequences.
module tb_alu_multicycle;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   cyc;

    alu_multicycle_if #(.WIDTH(16)) bus ();

    alu_multicycle #(
        .WIDTH (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        fwe;
        logic [15:0] res;
        logic [3:0]  fl;
    } vec_t;

    vec_t vecs[19];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issues one op and waits for done; returns latency (edges after accept) and busy cycles.
    task automatic run_op(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                          input logic fwe, output int lat, output int busy_n, output int done_cyc);
        int k;
        @(negedge clk);
        k = 0;
        while (bus.busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        bus.start   = 1'b1;
        bus.op      = o;
        bus.a       = x;
        bus.b       = y;
        bus.flag_we = fwe;
        @(posedge clk);
        #1;
        busy_n = bus.busy ? 1 : 0;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.op      = 4'($urandom);
        bus.a       = 16'($urandom);
        bus.b       = 16'($urandom);
        bus.flag_we = 1'($urandom);
        lat      = -1;
        done_cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat      = i;
                done_cyc = cyc;
                break;
            end
            if (bus.busy) busy_n++;
        end
    endtask

    initial begin
        int lat, busy_n, dc, dc2, exp_lat, dn, first, c0;
        logic [15:0] r;

        total = 0;
        bad   = 0;
        vecs[0]  = '{4'd0,  16'hFFFF, 16'h0001, 1'b1, 16'h0000, 4'b0011};
        vecs[1]  = '{4'd2,  16'h0003, 16'h0005, 1'b1, 16'hFFFE, 4'b0110};
        vecs[2]  = '{4'd3,  16'h000A, 16'h0002, 1'b1, 16'h0007, 4'b0000};
        vecs[3]  = '{4'd10, 16'd100,  16'd7,    1'b1, 16'd2,    4'b0000};
        vecs[4]  = '{4'd9,  16'd100,  16'd7,    1'b1, 16'd14,   4'b0000};
        vecs[5]  = '{4'd9,  16'd9,    16'd0,    1'b1, 16'hFFFF, 4'b1100};
        vecs[6]  = '{4'd10, 16'd9,    16'd0,    1'b1, 16'd9,    4'b1000};
        vecs[7]  = '{4'd0,  16'h7FFF, 16'h0001, 1'b1, 16'h8000, 4'b1100};
        vecs[8]  = '{4'd7,  16'h8001, 16'h0000, 1'b1, 16'h0002, 4'b0010};
        vecs[9]  = '{4'd1,  16'h0001, 16'h0001, 1'b1, 16'h0003, 4'b0000};
        vecs[10] = '{4'd8,  16'h0003, 16'h0000, 1'b1, 16'h0001, 4'b0010};
        vecs[11] = '{4'd4,  16'hF0F0, 16'h0FF0, 1'b1, 16'h00F0, 4'b0010};
        vecs[12] = '{4'd5,  16'h0000, 16'h0000, 1'b0, 16'h0000, 4'b0010};
        vecs[13] = '{4'd6,  16'hAAAA, 16'hFFFF, 1'b1, 16'h5555, 4'b0010};
        vecs[14] = '{4'd11, 16'h1234, 16'h8000, 1'b1, 16'h8000, 4'b0110};
        vecs[15] = '{4'd12, 16'h0005, 16'h0005, 1'b1, 16'h0000, 4'b0110};
        vecs[16] = '{4'd2,  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 4'b1000};
        vecs[17] = '{4'd9,  16'hFFFF, 16'h0001, 1'b1, 16'hFFFF, 4'b0100};
        vecs[18] = '{4'd10, 16'h0000, 16'h0005, 1'b1, 16'h0000, 4'b0001};

        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.op      = '0;
        bus.a       = '0;
        bus.b       = '0;
        bus.flag_we = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset result", 32'(bus.result), 32'h0);
        check("reset busy",   32'(bus.busy),   32'h0);
        check("reset done",   32'(bus.done),   32'h0);
        check("reset flags",  32'(bus.flags),  32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            exp_lat = ((vecs[i].op == 4'd9 || vecs[i].op == 4'd10) && vecs[i].b != 16'd0) ? 17 : 1;
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].fwe, lat, busy_n, dc);
            check($sformatf("vec%0d result", i),  32'(bus.result), 32'(vecs[i].res));
            check($sformatf("vec%0d flags", i),   32'(bus.flags),  32'(vecs[i].fl));
            check($sformatf("vec%0d latency", i), 32'(lat),        32'(exp_lat));
            check($sformatf("vec%0d busy", i),    32'(busy_n),     32'(exp_lat));
        end

        // Back-to-back single-cycle ops: accepted in the done cycle, 2 cycles apart.
        run_op(4'd0, 16'd1, 16'd1, 1'b1, lat, busy_n, dc);
        run_op(4'd0, 16'd2, 16'd2, 1'b1, lat, busy_n, dc2);
        check("b2b result", 32'(bus.result), 32'd4);
        check("b2b spacing", 32'(dc2 - dc), 32'd2);
        @(posedge clk);
        #1;
        check("done single pulse", 32'(bus.done), 32'h0);

        // Start while busy must be ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 4'd9; bus.a = 16'd1000; bus.b = 16'd10; bus.flag_we = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.op = 4'd0; bus.a = 16'd1; bus.b = 16'd1;
        @(negedge clk);
        bus.start = 1'b0;
        dn = 0;
        first = -1;
        r = '0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                dn++;
                if (first < 0) begin
                    first = cyc - c0;
                    r = bus.result;
                end
            end
        end
        check("ignore done count", 32'(dn), 32'd1);
        check("ignore latency", 32'(first), 32'd17);
        check("ignore result", 32'(r), 32'd100);

        // Reset in the middle of a MOD aborts it silently.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 4'd10; bus.a = 16'd100; bus.b = 16'd7; bus.flag_we = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort result", 32'(bus.result), 32'h0);
        check("abort flags",  32'(bus.flags),  32'h1);
        check("abort busy",   32'(bus.busy),   32'h0);
        check("abort done",   32'(bus.done),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.done) dn++;
        end
        check("abort no done", 32'(dn), 32'd0);
        run_op(4'd0, 16'd2, 16'd3, 1'b1, lat, busy_n, dc);
        check("post-reset add", 32'(bus.result), 32'd5);
        check("post-reset flags", 32'(bus.flags), 32'h0);
        check("post-reset latency", 32'(lat), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised successor to the CPU's single-cycle ALU; adds iterative DIV/MOD, a start/busy/done handshake and an internal Z/C/S/V flags register.
- Sits between the A/B registers and the bus.
- The controller pulses start with an opcode, then waits for done before enabling the result onto the bus.
- Single-cycle ops complete in 1 cycle; DIV/MOD complete in WIDTH+1 cycles.

Parameters:
- WIDTH, 16, operand/result width in bits (≥4).
- CNT_W, $clog2(WIDTH+1), width of the division iteration counter.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request; sampled only when busy=0.
- op  in  4  opcode: ADD=0, ADDC=1, SUB=2, SUBB=3, AND=4, OR=5, XOR=6, SHL=7, SHR=8, DIV=9, MOD=10, PASSB=11; 12-15 reserved.
- a  in  WIDTH  operand A; captured at start.
- b  in  WIDTH  operand B; captured at start.
- flag_we  in  1  captured at start; if 1, flags update on completion.
- result  out  WIDTH  registered result; holds until the next completion.
- busy  out  1  high while an op is in flight.
- done  out  1  one-cycle pulse, coincident with result/flags becoming valid.
- flags  out  4  {V,S,C,Z} = bits [3:0] as {3:V, 2:S, 1:C, 0:Z}.

Behaviour:
- Reset (rst_n=0 at posedge): result=0, busy=0, done=0, flags=4'b0001 (Z=1), FSM→IDLE, counter=0. Reset aborts any in-flight op with no done pulse.
- FSM states: IDLE, DIV, FIN.
  - IDLE: start=1 latches a, b, op, flag_we and the current C. Single-cycle ops go to FIN. DIV/MOD with b≠0 go to DIV, counter=WIDTH. DIV/MOD with b=0 go to FIN.
  - DIV: restoring division, one quotient bit per cycle; counter decrements; at 0 → FIN.
  - FIN: result/flags written, done=1; next state IDLE.
- busy=1 in DIV and FIN states, and in the cycle after start is accepted.
- Latency, start accepted at edge N:
  - single-cycle op: done=1 and result valid after edge N+1;
  - DIV/MOD: done after edge N+WIDTH+1.
- start while busy=1 is ignored entirely; no queueing.
- start in the same cycle done=1 is accepted; back-to-back throughput is 1 op per 2 cycles for single-cycle ops.
- Arithmetic is WIDTH+1 bits internally:
  - ADD/ADDC: C = carry out of bit WIDTH-1.
  - SUB/SUBB: C = borrow (1 when a < b + cin).
  - ADDC/SUBB: cin = C latched at start.
  - V = two's-complement signed overflow for ADD/ADDC/SUB/SUBB.
- Logic ops and PASSB: C unchanged, V=0.
- SHL/SHR: shift a by 1, zero fill; C = bit shifted out; V=0.
- DIV: result = quotient. MOD: result = remainder. C unchanged, V=0.
- Divide by zero: DIV result = all-ones; MOD result = a; V=1; C unchanged; takes 1 cycle.
- Z = (result==0); S = result[WIDTH-1].
- Z/S/V/C are written only when the latched flag_we=1; otherwise flags hold.
- Reserved opcodes: result=0, flags untouched, done still pulses after 1 cycle.
- Inputs a, b, op may change freely after start is accepted.

Decomposition:
- Package alu_pkg holds:
  - op enum (4-bit) with the values above;
  - flag indices FLAG_Z=0, FLAG_C=1, FLAG_S=2, FLAG_V=3;
  - FSM state typedef.
- Sub-module alu_div_iter (WIDTH param):
  - inputs: clk, rst_n, load, dividend, divisor;
  - outputs: quotient, remainder;
  - one restoring step per cycle while enabled.
- Top module alu_multicycle holds the FSM, the single-cycle datapath and the flags register.

Test Plan:
- Reset, then ADD a=16'hFFFF b=1 flag_we=1 → done 1 cycle later; result=0; flags Z=1 C=1 S=0 V=0.
- SUB a=3 b=5 → result=16'hFFFE, C=1, S=1. Then SUBB a=10 b=2 → result=7 (borrow consumed), C=0.
- MOD a=100 b=7 → busy high 17 cycles, done at edge N+17, result=2. DIV same operands → result=14.
- DIV a=9 b=0 → done after 1 cycle, result=16'hFFFF, V=1, C unchanged. MOD a=9 b=0 → result=9.
- Start DIV, pulse start with ADD at cycle 5 → ADD ignored; single done pulse with the DIV result.
- Start MOD, drop rst_n at cycle 8 → no done pulse; result=0; flags=4'b0001; busy=0. A new ADD 2+3 afterwards gives 5.
